// File: rtl/clk_divider_multi.sv
// Multi-channel run-time programmable clock divider with 50% duty outputs and rising-edge ticks.
// Half-period updates are shadowed and committed at each channel's terminal count, on sync, or while disabled.
module clk_divider_multi #(
    parameter int unsigned          NUM_CH       = 4,
    parameter int unsigned          CNT_W        = 19,
    parameter logic [CNT_W-1:0]     DEFAULT_HALF = CNT_W'(262145),
    localparam int unsigned         CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync,
    input  logic              div_wr,
    input  logic [CH_W-1:0]   div_ch,
    input  logic [CNT_W-1:0]  div_data,
    output logic [NUM_CH-1:0] divided_clk,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] upd_pending
);

    // Indices at or above NUM_CH never match a channel, so such writes are dropped.
    logic [31:0] ch_ext;
    assign ch_ext = 32'(div_ch);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] half;
        logic [CNT_W-1:0] pend;
        logic [CNT_W-1:0] next_pend;
        logic             dclk_q;
        logic             tick_q;
        logic             upd_q;
        logic             hit;
        logic             terminal;

        // NOTE: every signal written here gets a value on every pass, otherwise a latch is inferred.
        always_comb begin
            hit       = div_wr && (ch_ext == 32'(i));
            next_pend = hit ? div_data : pend;
            terminal  = (cnt == half);
        end

        // NOTE: sequential state uses non-blocking assignments so all channels update from pre-edge values.
        always_ff @(posedge clk_in or negedge rst_n) begin
            if (!rst_n) begin
                cnt    <= '0;
                half   <= DEFAULT_HALF;
                pend   <= DEFAULT_HALF;
                dclk_q <= 1'b0;
                tick_q <= 1'b0;
                upd_q  <= 1'b0;
            end else begin
                pend <= next_pend;
                if (!en[i]) begin
                    // Frozen channel: nothing to glitch, so the shadow value lands at once.
                    tick_q <= 1'b0;
                    half   <= next_pend;
                    upd_q  <= 1'b0;
                end else if (sync) begin
                    cnt    <= '0;
                    dclk_q <= 1'b0;
                    tick_q <= 1'b0;
                    half   <= next_pend;
                    upd_q  <= 1'b0;
                end else if (terminal) begin
                    // Toggle decision used the old half; the new one governs the next phase from cnt=0.
                    cnt    <= '0;
                    dclk_q <= ~dclk_q;
                    tick_q <= ~dclk_q;
                    half   <= next_pend;
                    upd_q  <= 1'b0;
                end else begin
                    cnt    <= cnt + CNT_W'(1);
                    tick_q <= 1'b0;
                    if (hit) begin
                        upd_q <= 1'b1;
                    end
                end
            end
        end

        assign divided_clk[i] = dclk_q;
        assign tick[i]        = tick_q;
        assign upd_pending[i] = upd_q;
    end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Directed bench for clk_divider_multi: a cycle model feeds an expectation queue checked every cycle,
// plus directed period/tick-count checks and a second small instance for out-of-range channel writes.
module tb_clk_divider_multi;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned CH_W   = 2;
    localparam logic [7:0]  DEF    = 8'd3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] en;
    logic       sync;
    logic       div_wr;
    logic [1:0] div_ch;
    logic [7:0] div_data;
    logic [3:0] divided_clk;
    logic [3:0] tick;
    logic [3:0] upd_pending;

    logic [2:0] en_b;
    logic       sync_b;
    logic       div_wr_b;
    logic [1:0] div_ch_b;
    logic [7:0] div_data_b;
    logic [2:0] divided_clk_b;
    logic [2:0] tick_b;
    logic [2:0] upd_pending_b;

    always #5 clk = ~clk;

    clk_divider_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_HALF(DEF)) dut (
        .clk_in(clk), .rst_n(rst_n), .en(en), .sync(sync), .div_wr(div_wr),
        .div_ch(div_ch), .div_data(div_data), .divided_clk(divided_clk),
        .tick(tick), .upd_pending(upd_pending)
    );

    // Three channels with a 2-bit index: index 3 is out of range.
    clk_divider_multi #(.NUM_CH(3), .CNT_W(CNT_W), .DEFAULT_HALF(DEF)) dut_b (
        .clk_in(clk), .rst_n(rst_n), .en(en_b), .sync(sync_b), .div_wr(div_wr_b),
        .div_ch(div_ch_b), .div_data(div_data_b), .divided_clk(divided_clk_b),
        .tick(tick_b), .upd_pending(upd_pending_b)
    );

    typedef struct packed {
        logic [3:0] dclk;
        logic [3:0] tck;
        logic [3:0] upd;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic [7:0] m_cnt  [4];
    logic [7:0] m_half [4];
    logic [7:0] m_pend [4];
    logic [3:0] m_dclk;
    logic [3:0] m_tick;
    logic [3:0] m_upd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_cnt[i]  = 8'd0;
            m_half[i] = DEF;
            m_pend[i] = DEF;
        end
        m_dclk = 4'd0;
        m_tick = 4'd0;
        m_upd  = 4'd0;
    endtask

    // Advance the model by one clk edge using the inputs currently driven.
    task automatic model_step();
        logic [7:0] np;
        logic       hit;
        for (int i = 0; i < 4; i++) begin
            hit = div_wr && (int'(div_ch) == i);
            np  = hit ? div_data : m_pend[i];
            if (!en[i]) begin
                m_tick[i] = 1'b0;
                m_half[i] = np;
                m_upd[i]  = 1'b0;
            end else if (sync) begin
                m_cnt[i]  = 8'd0;
                m_dclk[i] = 1'b0;
                m_tick[i] = 1'b0;
                m_half[i] = np;
                m_upd[i]  = 1'b0;
            end else if (m_cnt[i] == m_half[i]) begin
                m_cnt[i]  = 8'd0;
                m_tick[i] = ~m_dclk[i];
                m_dclk[i] = ~m_dclk[i];
                m_half[i] = np;
                m_upd[i]  = 1'b0;
            end else begin
                m_cnt[i]  = m_cnt[i] + 8'd1;
                m_tick[i] = 1'b0;
                if (hit) m_upd[i] = 1'b1;
            end
            m_pend[i] = np;
        end
    endtask

    task automatic cycle();
        exp_t e;
        model_step();
        e.dclk = m_dclk;
        e.tck  = m_tick;
        e.upd  = m_upd;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        check("sb_divided_clk", divided_clk, e.dclk);
        check("sb_tick", tick, e.tck);
        check("sb_upd_pending", upd_pending, e.upd);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int ticks;
        int highs;
        int ticks_b;
        logic seen;

        rst_n = 1'b0; en = 4'h0; sync = 1'b0; div_wr = 1'b0; div_ch = 2'd0; div_data = 8'd0;
        en_b = 3'b000; sync_b = 1'b0; div_wr_b = 1'b0; div_ch_b = 2'd0; div_data_b = 8'd0;
        model_reset();

        // Reset state
        #12;
        check("rst_divided_clk", divided_clk, 4'h0);
        check("rst_tick", tick, 4'h0);
        check("rst_upd_pending", upd_pending, 4'h0);
        check("rst_b_divided_clk", divided_clk_b, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        en    = 4'hf;

        // 1: default half 3 -> period 8
        ticks = 0; highs = 0;
        for (int n = 0; n < 16; n++) begin
            cycle();
            ticks += int'(tick[0]);
            highs += int'(divided_clk[0]);
        end
        check("t1_ticks_ch0", ticks, 2);
        check("t1_high_cycles_ch0", highs, 8);

        // 2: write H=1 to ch1 mid-period
        cycle();
        div_wr = 1'b1; div_ch = 2'd1; div_data = 8'd1;
        cycle();
        div_wr = 1'b0;
        check("t2_upd_set", upd_pending[1], 1'b1);
        k = 0;
        while (m_upd[1] && k < 20) begin cycle(); k++; end
        check("t2_commit_wait", k < 20, 1'b1);
        ticks = 0; highs = 0;
        for (int n = 0; n < 16; n++) begin
            cycle();
            ticks += int'(tick[1]);
            highs += int'(tick[0]);
        end
        check("t2_ticks_ch1_period4", ticks, 4);
        check("t2_ticks_ch0_period8", highs, 2);

        // 3: write H=0 to ch2 on its terminal cycle
        k = 0;
        while (m_cnt[2] != m_half[2] && k < 20) begin cycle(); k++; end
        check("t3_terminal_wait", k < 20, 1'b1);
        div_wr = 1'b1; div_ch = 2'd2; div_data = 8'd0;
        cycle();
        div_wr = 1'b0;
        seen = upd_pending[2];
        ticks = 0;
        for (int n = 0; n < 8; n++) begin
            cycle();
            ticks += int'(tick[2]);
            seen |= upd_pending[2];
        end
        check("t3_upd_never_set", seen, 1'b0);
        check("t3_ticks_ch2_period2", ticks, 4);

        // 4: freeze ch0 mid-high phase
        k = 0;
        while (!(m_dclk[0] && m_cnt[0] == 8'd1) && k < 20) begin cycle(); k++; end
        check("t4_midhigh_wait", k < 20, 1'b1);
        en[0] = 1'b0;
        ticks = 0; highs = 0;
        for (int n = 0; n < 5; n++) begin
            cycle();
            ticks += int'(tick[0]);
            highs += int'(divided_clk[0]);
        end
        check("t4_frozen_high", highs, 5);
        check("t4_no_tick", ticks, 0);
        en[0] = 1'b1;
        cycle();
        cycle();
        check("t4_resume_still_high", divided_clk[0], 1'b1);
        cycle();
        check("t4_resume_falls", divided_clk[0], 1'b0);

        // 5: sync with ch2 disabled
        en   = 4'b1011;
        sync = 1'b1;
        cycle();
        sync = 1'b0;
        check("t5_synced_low", divided_clk & 4'b1011, 4'b0000);
        for (int n = 1; n <= 4; n++) begin
            cycle();
            if (n < 4) check("t5_ch3_no_tick_yet", tick[3], 1'b0);
        end
        check("t5_aligned_tick_ch0", tick[0], 1'b1);
        check("t5_aligned_tick_ch3", tick[3], 1'b1);
        en = 4'hf;

        // 7: async reset with a pending write on ch3
        k = 0;
        while (!(m_dclk[3] && m_cnt[3] == 8'd0) && k < 20) begin cycle(); k++; end
        check("t7_phase_wait", k < 20, 1'b1);
        div_wr = 1'b1; div_ch = 2'd3; div_data = 8'd5;
        cycle();
        div_wr = 1'b0;
        check("t7_upd_before_reset", upd_pending[3], 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("t7_async_divided_clk", divided_clk, 4'h0);
        check("t7_async_tick", tick, 4'h0);
        check("t7_async_upd_pending", upd_pending, 4'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        en    = 4'hf;

        // 6 (second instance): out-of-range index 3 ignored, periods unchanged
        en_b = 3'b111; div_wr_b = 1'b1; div_ch_b = 2'd3; div_data_b = 8'd0;
        ticks = 0; ticks_b = 0;
        for (int n = 1; n <= 16; n++) begin
            cycle();
            div_wr_b = 1'b0;
            ticks   += int'(tick[3]);
            ticks_b += int'(tick_b[2]);
            check("t6_b_upd_none", upd_pending_b, 3'b000);
            check("t6_b_divided_clk", divided_clk_b, ((n / 4) % 2 != 0) ? 3'b111 : 3'b000);
        end
        check("t7_ch3_default_period", ticks, 2);
        check("t6_b_ticks_ch2", ticks_b, 2);
        div_wr_b = 1'b1; div_ch_b = 2'd1; div_data_b = 8'd1;
        cycle();
        div_wr_b = 1'b0;
        check("t6_b_valid_write", upd_pending_b, 3'b010);

        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
